// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the 4-way instruction cache refill path.
package icache_refill_ctrl_pkg;

    localparam int ICACHE_WAYS = 4;
    localparam int INDEX_BITS  = 6;
    localparam int OFFSET_BITS = 5;
    localparam int WORD_BITS   = OFFSET_BITS - 2;
    localparam int LINE_WORDS  = 2 ** WORD_BITS;
    localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int NUM_SETS    = 2 ** INDEX_BITS;

    typedef logic [INDEX_BITS-1:0] index_t;
    typedef logic [TAG_BITS-1:0]   tag_t;
    typedef logic [1:0]            way_t;
    typedef logic [2:0]            plru_t;
    typedef logic [WORD_BITS-1:0]  word_t;

    typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} refill_state_t;

    // Lowest-numbered invalid way; only meaningful when at least one bit is 0.
    function automatic way_t first_free_way(input logic [ICACHE_WAYS-1:0] valid_ways);
        way_t w;
        w = '0;
        for (int i = ICACHE_WAYS - 1; i >= 0; i--) begin
            if (!valid_ways[i]) w = way_t'(i);
        end
        return w;
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_plru_tree4.sv
// Combinational 4-way tree-PLRU: victim lookup and touch update for one set.
module plru_tree4
    import icache_refill_ctrl_pkg::*;
(
    input  plru_t plru_in,
    input  way_t  touch_way,
    output way_t  victim,
    output plru_t plru_out
);

    always_comb begin
        victim   = {plru_in[0], (plru_in[0] ? plru_in[2] : plru_in[1])};
        plru_out = plru_in;
        plru_out[0] = ~touch_way[1];
        if (touch_way[1]) begin
            plru_out[2] = ~touch_way[0];
        end else begin
            plru_out[1] = ~touch_way[0];
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill sequencer; owns per-set PLRU state and
// streams one burst line from memory into the chosen victim way.
//
// state  | meaning
// IDLE   | accepting lookups; hits touch PLRU, a miss latches the request
// REQ    | burst read request presented, waiting for mem_req_ready
// FILL   | accepting read beats, one data-array word write per beat
// COMMIT | one-cycle tag/valid write and refill_done pulse
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lk_valid,
    output logic                  lk_ready,
    input  logic                  lk_hit,
    input  logic [1:0]            lk_hit_way,
    input  logic [ICACHE_WAYS-1:0] lk_valid_ways,
    input  logic [INDEX_BITS-1:0] lk_index,
    input  logic [TAG_BITS-1:0]   lk_tag,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [31:0]           mem_req_addr,
    output logic [7:0]            mem_req_len,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rlast,
    output logic                  mem_rready,
    output logic                  fill_we,
    output logic [1:0]            fill_way,
    output logic [INDEX_BITS-1:0] fill_index,
    output logic [WORD_BITS-1:0]  fill_word,
    output logic [31:0]           fill_data,
    output logic                  tag_we,
    output logic [1:0]            tag_way,
    output logic [INDEX_BITS-1:0] tag_index,
    output logic [TAG_BITS-1:0]   tag_value,
    output logic                  refill_done,
    output logic                  rlast_err,
    output logic                  busy
);

    refill_state_t state_q, state_d;
    word_t         beat_q, beat_d;
    index_t        idx_q, idx_d;
    tag_t          tag_q, tag_d;
    way_t          way_q, way_d;
    plru_t         plru_q [NUM_SETS];
    plru_t         plru_d [NUM_SETS];

    plru_t set_plru, hit_plru, miss_plru;
    way_t  plru_victim, miss_way, unused_miss_tree_victim;
    logic  last_beat;

    assign set_plru  = plru_q[lk_index];
    assign miss_way  = (&lk_valid_ways) ? plru_victim : first_free_way(lk_valid_ways);
    assign last_beat = (beat_q == word_t'(LINE_WORDS - 1));

    // Both trees see the same set state, so the hit tree also supplies the victim.
    plru_tree4 u_hit_tree (
        .plru_in   (set_plru),
        .touch_way (lk_hit_way),
        .victim    (plru_victim),
        .plru_out  (hit_plru)
    );

    plru_tree4 u_miss_tree (
        .plru_in   (set_plru),
        .touch_way (miss_way),
        .victim    (unused_miss_tree_victim),
        .plru_out  (miss_plru)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            way_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            way_q   <= way_d;
            plru_q  <= plru_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lk_valid && !lk_hit) state_d = REQ;
            REQ:     if (mem_req_ready) state_d = FILL;
            FILL:    if (mem_rvalid && last_beat) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_d = beat_q;
        idx_d  = idx_q;
        tag_d  = tag_q;
        way_d  = way_q;
        plru_d = plru_q;
        if (state_q == IDLE && lk_valid) begin
            if (lk_hit) begin
                plru_d[lk_index] = hit_plru;
            end else begin
                idx_d            = lk_index;
                tag_d            = lk_tag;
                way_d            = miss_way;
                plru_d[lk_index] = miss_plru;
            end
        end
        if (state_q == REQ && mem_req_ready) beat_d = '0;
        // Beat count wraps to 0 on the final beat; mem_rlast never steers it.
        if (state_q == FILL && mem_rvalid) beat_d = beat_q + 1'b1;
    end

    always_comb begin
        lk_ready      = (state_q == IDLE);
        busy          = (state_q != IDLE);
        mem_req_valid = (state_q == REQ);
        mem_req_addr  = {tag_q, idx_q, {OFFSET_BITS{1'b0}}};
        mem_req_len   = 8'(LINE_WORDS - 1);
        mem_rready    = (state_q == FILL);
        fill_we       = (state_q == FILL) && mem_rvalid;
        fill_way      = way_q;
        fill_index    = idx_q;
        fill_word     = beat_q;
        fill_data     = mem_rdata;
        rlast_err     = fill_we && (mem_rlast != last_beat);
        tag_we        = (state_q == COMMIT);
        refill_done   = (state_q == COMMIT);
        tag_way       = way_q;
        tag_index     = idx_q;
        tag_value     = tag_q;
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus pushes expected bus
// requests, fill writes and commits; a negedge monitor pops and compares.
module tb_icache_refill_ctrl;
    import icache_refill_ctrl_pkg::*;

    logic        clk, reset;
    logic        lk_valid, lk_ready, lk_hit;
    logic [1:0]  lk_hit_way;
    logic [3:0]  lk_valid_ways;
    index_t      lk_index;
    tag_t        lk_tag;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [7:0]  mem_req_len;
    logic        mem_rvalid, mem_rlast, mem_rready;
    logic [31:0] mem_rdata;
    logic        fill_we;
    logic [1:0]  fill_way;
    index_t      fill_index;
    logic [2:0]  fill_word;
    logic [31:0] fill_data;
    logic        tag_we;
    logic [1:0]  tag_way;
    index_t      tag_index;
    tag_t        tag_value;
    logic        refill_done, rlast_err, busy;

    icache_refill_ctrl dut (
        .clk(clk), .reset(reset),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_hit(lk_hit),
        .lk_hit_way(lk_hit_way), .lk_valid_ways(lk_valid_ways),
        .lk_index(lk_index), .lk_tag(lk_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
        .mem_rready(mem_rready),
        .fill_we(fill_we), .fill_way(fill_way), .fill_index(fill_index),
        .fill_word(fill_word), .fill_data(fill_data),
        .tag_we(tag_we), .tag_way(tag_way), .tag_index(tag_index),
        .tag_value(tag_value), .refill_done(refill_done),
        .rlast_err(rlast_err), .busy(busy)
    );

    typedef struct {
        way_t        way;
        index_t      idx;
        logic [2:0]  word;
        logic [31:0] data;
        logic        err;
    } fill_exp_t;

    typedef struct {
        way_t   way;
        index_t idx;
        tag_t   tag;
    } commit_exp_t;

    logic [31:0] req_q [$];
    fill_exp_t   fill_q [$];
    commit_exp_t commit_q [$];

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_en  = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input index_t idx, input int b);
        return 32'hC0DE0000 | {18'h0, idx, 8'(b)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_req_valid) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    chk("mem_req_addr", mem_req_addr, req_q[0]);
                    chk("mem_req_len", 32'(mem_req_len), 32'd7);
                    if (mem_req_ready) void'(req_q.pop_front());
                end
            end
            if (fill_we) begin
                if (fill_q.size() == 0) begin
                    chk("unexpected_fill_we", 32'd1, 32'd0);
                end else begin
                    fill_exp_t e;
                    e = fill_q.pop_front();
                    chk("fill_way", 32'(fill_way), 32'(e.way));
                    chk("fill_index", 32'(fill_index), 32'(e.idx));
                    chk("fill_word", 32'(fill_word), 32'(e.word));
                    chk("fill_data", fill_data, e.data);
                    chk("rlast_err", 32'(rlast_err), 32'(e.err));
                end
            end else if (rlast_err) begin
                chk("rlast_err_without_beat", 32'd1, 32'd0);
            end
            if (tag_we || refill_done) begin
                chk("refill_done_eq_tag_we", 32'(refill_done), 32'(tag_we));
                if (commit_q.size() == 0) begin
                    chk("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    commit_exp_t c;
                    c = commit_q.pop_front();
                    chk("tag_way", 32'(tag_way), 32'(c.way));
                    chk("tag_index", 32'(tag_index), 32'(c.idx));
                    chk("tag_value", 32'(tag_value), 32'(c.tag));
                end
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40 && !lk_ready; i++) step();
        chk("lk_ready_wait", 32'(lk_ready), 32'd1);
    endtask

    task automatic do_hit(input index_t idx, input way_t w);
        wait_ready();
        lk_valid = 1; lk_hit = 1; lk_hit_way = w; lk_index = idx;
        step();
        lk_valid = 0; lk_hit = 0;
        chk("hit_stays_idle", 32'({lk_ready, busy}), 32'b10);
    endtask

    task automatic do_miss(input index_t idx, input tag_t tag, input logic [3:0] vways,
                           input way_t exp_way, input int req_wait, input int gap,
                           input logic [7:0] rlast_mask);
        commit_exp_t c;
        wait_ready();
        req_q.push_back({tag, idx, 5'b0});
        for (int b = 0; b < 8; b++) begin
            fill_exp_t e;
            e.way = exp_way; e.idx = idx; e.word = 3'(b);
            e.data = beat_data(idx, b);
            e.err = rlast_mask[b] != (b == 7);
            fill_q.push_back(e);
        end
        c.way = exp_way; c.idx = idx; c.tag = tag;
        commit_q.push_back(c);
        lk_valid = 1; lk_hit = 0; lk_index = idx; lk_tag = tag; lk_valid_ways = vways;
        step();
        lk_valid = 0;
        chk("req_after_accept", 32'({mem_req_valid, lk_ready, busy}), 32'b101);
        repeat (req_wait) step();
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        chk("mem_rready_in_fill", 32'(mem_rready), 32'd1);
        for (int b = 0; b < 8; b++) begin
            repeat (gap) begin
                mem_rvalid = 0;
                step();
            end
            mem_rvalid = 1; mem_rdata = beat_data(idx, b); mem_rlast = rlast_mask[b];
            step();
        end
        mem_rvalid = 0; mem_rlast = 0;
        step();
        chk("idle_after_commit", 32'({lk_ready, busy}), 32'b10);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("fill_q_drained", 32'(fill_q.size()), 32'd0);
        chk("commit_q_drained", 32'(commit_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; lk_valid = 0; lk_hit = 0; lk_hit_way = 0; lk_valid_ways = 0;
        lk_index = 0; lk_tag = 0; mem_req_ready = 0; mem_rvalid = 0;
        mem_rdata = 0; mem_rlast = 0;
        step();
        step();
        chk("reset_outputs",
            32'({lk_ready, busy, mem_req_valid, mem_rready, fill_we, tag_we, refill_done, rlast_err}),
            32'b1000_0000);
        reset = 0;
        mon_en = 1;
        step();

        // Empty set: way 0, PLRU[5] becomes 3'b011.
        do_miss(6'd5, 21'h1ABCD, 4'b0000, 2'd0, 0, 0, 8'h80);

        // Full set 3: PLRU victim 0, hit way 2, then victim 1.
        do_miss(6'd3, 21'h00111, 4'b1111, 2'd0, 0, 0, 8'h80);
        do_hit(6'd3, 2'd2);
        do_miss(6'd3, 21'h00222, 4'b1111, 2'd1, 0, 0, 8'h80);

        // Free way 2 beats the PLRU choice (way 0 for a fresh set).
        do_miss(6'd7, 21'h0BEEF, 4'b1011, 2'd2, 0, 0, 8'h80);

        // Held-off request and 2-cycle beat gaps.
        do_miss(6'd9, 21'h12345, 4'b0001, 2'd1, 5, 2, 8'h80);

        // Stray rlast on beat 3 (and proper rlast on beat 7).
        do_miss(6'd10, 21'h0F0F0, 4'b0000, 2'd0, 0, 0, 8'h88);

        // PLRU[5]=011 -> victim 2; set 3 keeps b2=1 from the way-2 hit -> victim 3.
        do_miss(6'd5, 21'h1AAAA, 4'b1111, 2'd2, 0, 0, 8'h80);
        do_miss(6'd3, 21'h00333, 4'b1111, 2'd3, 0, 0, 8'h80);

        // Back-to-back hits: touch 3 then 0 leaves victim 2.
        do_hit(6'd20, 2'd3);
        do_hit(6'd20, 2'd0);
        do_miss(6'd20, 21'h04444, 4'b1111, 2'd2, 0, 0, 8'h80);

        // Reset during FILL beat 4.
        wait_ready();
        req_q.push_back({21'h00C0C, 6'd12, 5'b0});
        for (int b = 0; b < 5; b++) begin
            fill_exp_t e;
            e.way = 2'd0; e.idx = 6'd12; e.word = 3'(b);
            e.data = beat_data(6'd12, b); e.err = 1'b0;
            fill_q.push_back(e);
        end
        lk_valid = 1; lk_hit = 0; lk_index = 6'd12; lk_tag = 21'h00C0C; lk_valid_ways = 4'b0000;
        step();
        lk_valid = 0;
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        for (int b = 0; b < 5; b++) begin
            mem_rvalid = 1; mem_rdata = beat_data(6'd12, b); mem_rlast = 0;
            if (b == 4) reset = 1;
            step();
        end
        mem_rvalid = 0; reset = 0;
        chk("abort_reset_state",
            32'({lk_ready, busy, tag_we, refill_done, mem_rready, mem_req_valid}),
            32'b10_0000);
        repeat (3) step();
        chk("abort_fill_q_drained", 32'(fill_q.size()), 32'd0);
        chk("abort_req_q_drained", 32'(req_q.size()), 32'd0);

        // PLRU cleared: set 5 (was victim 1) now picks way 0.
        do_miss(6'd5, 21'h15555, 4'b1111, 2'd0, 0, 0, 8'h80);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
